// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision add/sub issue stage.
// Provides op encodings, special constants, flag bit positions and a
// helper that classifies a 32-bit IEEE-754 word as NaN / Inf / zero-exponent.
package fpu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_INF  = 1;
  localparam int unsigned FLG_NAN  = 2;
  localparam int unsigned FLG_W    = 3;

  // Field order gives the {is_nan, is_inf, is_zero} packing.
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fclass_t;

  // is_zero means a zero exponent, so subnormals are included.
  function automatic fclass_t classify(input logic [31:0] w);
    fclass_t c;
    c.is_nan  = (w[30:23] == EXP_MAX) && (w[22:0] != 23'd0);
    c.is_inf  = (w[30:23] == EXP_MAX) && (w[22:0] == 23'd0);
    c.is_zero = (w[30:23] == 8'd0);
    return c;
  endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// Synchronous FIFO holding queued add/sub requests.
// Ports: clk, rstn (sync, active-low), push/push_data, pop, pop_data_c
// (head entry), full_c, empty_c. Pointers carry one extra wrap bit so
// full and empty are distinguishable; push into a full FIFO is accepted
// only together with a pop in the same cycle.
module fpu_op_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Status decode and pointer advance.
  always_comb begin
    empty_c    = (wr_ptr_q == rd_ptr_q);
    full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop     = pop && !empty_c;
    do_push    = push && (!full_c || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    pop_data_c = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/result stage in front of a combinational single-precision
// subtract unit. Requests (op, a, b, tag) enter a FIFO via in_valid/in_ready,
// are registered as fu_x1/fu_x2 (add becomes sub with b's sign flipped),
// and the unit result fu_y is captured with special-operand overrides and
// returned via out_valid/out_ready with out_tag and out_flags {nan,inf,zero}.
// Optional macro FPU_ISSUE_PERF_EN adds perf_ops (output handshakes) and
// perf_stall (cycles with out_valid=1, out_ready=0) counters.
module fpu_addsub_issue
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fu_x1,
  output logic [31:0]      fu_x2,
  input  logic [31:0]      fu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  localparam int unsigned ENT_W = 1 + 32 + 32 + TAG_W;

  logic             rdy_q, rdy_d;
  logic             push, pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_wdata, fifo_rdata;
  logic             s2_en;

  logic             e_op;
  logic [31:0]      e_a, e_b, e_x2;
  logic [TAG_W-1:0] e_tag;

  // S1: operand register; op is folded into the sign of x2.
  logic             s1_v_q, s1_v_d;
  logic [31:0]      s1_x1_q, s1_x1_d;
  logic [31:0]      s1_x2_q, s1_x2_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  fclass_t          s1_ca_q, s1_ca_d;
  fclass_t          s1_cb_q, s1_cb_d;

  // S2: result register.
  logic             s2_v_q, s2_v_d;
  logic [31:0]      s2_y_q, s2_y_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [FLG_W-1:0] s2_flg_q, s2_flg_d;

  logic [31:0]      res_y;
  logic [FLG_W-1:0] res_flg;

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;
`endif

  fpu_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_data  (fifo_wdata),
    .pop        (pop),
    .pop_data_c (fifo_rdata),
    .full_c     (fifo_full),
    .empty_c    (fifo_empty)
  );

  // Handshake and pipeline advance.
  always_comb begin
    rdy_d      = 1'b1;
    s2_en      = !s2_v_q || out_ready;
    pop        = !fifo_empty && (!s1_v_q || s2_en);
    // A full FIFO still accepts when its head leaves this cycle.
    in_ready   = rdy_q && (!fifo_full || pop);
    push       = in_valid && in_ready;
    fifo_wdata = {in_op, in_a, in_b, in_tag};
    e_op       = fifo_rdata[ENT_W-1];
    e_a        = fifo_rdata[ENT_W-2 -: 32];
    e_b        = fifo_rdata[TAG_W +: 32];
    e_tag      = fifo_rdata[TAG_W-1:0];
    e_x2       = (e_op == OP_SUB) ? e_b : {~e_b[31], e_b[30:0]};
  end

  // Special-operand override of the unit result, priority nan > inf > zero.
  always_comb begin
    res_y   = fu_y;
    res_flg = '0;
    if (s1_ca_q.is_nan || s1_cb_q.is_nan) begin
      res_y            = QNAN;
      res_flg[FLG_NAN] = 1'b1;
    end else if (s1_ca_q.is_inf && s1_cb_q.is_inf) begin
      // Inf - Inf of equal sign is invalid; opposite signs give x1.
      if (s1_x1_q[31] == s1_x2_q[31]) begin
        res_y            = QNAN;
        res_flg[FLG_NAN] = 1'b1;
      end else begin
        res_y            = s1_x1_q;
        res_flg[FLG_INF] = 1'b1;
      end
    end else if (s1_ca_q.is_inf) begin
      res_y            = s1_x1_q;
      res_flg[FLG_INF] = 1'b1;
    end else if (s1_cb_q.is_inf) begin
      res_y            = {~s1_x2_q[31], s1_x2_q[30:0]};
      res_flg[FLG_INF] = 1'b1;
    end else if (s1_ca_q.is_zero && s1_cb_q.is_zero) begin
      res_y             = '0;
      res_flg[FLG_ZERO] = 1'b1;
    end else if (fu_y[30:23] == EXP_MAX) begin
      res_flg[FLG_INF] = 1'b1;
    end else if (fu_y[30:23] == 8'd0) begin
      res_flg[FLG_ZERO] = 1'b1;
    end
  end

  // Next-state for S1/S2 and counters.
  always_comb begin
    s1_v_d   = s1_v_q;
    s1_x1_d  = s1_x1_q;
    s1_x2_d  = s1_x2_q;
    s1_tag_d = s1_tag_q;
    s1_ca_d  = s1_ca_q;
    s1_cb_d  = s1_cb_q;
    s2_v_d   = s2_v_q;
    s2_y_d   = s2_y_q;
    s2_tag_d = s2_tag_q;
    s2_flg_d = s2_flg_q;

    if (pop) begin
      s1_v_d   = 1'b1;
      s1_x1_d  = e_a;
      s1_x2_d  = e_x2;
      s1_tag_d = e_tag;
      s1_ca_d  = classify(e_a);
      s1_cb_d  = classify(e_x2);
    end else if (s2_en) begin
      s1_v_d = 1'b0;
    end

    if (s2_en) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_y_d   = res_y;
        s2_tag_d = s1_tag_q;
        s2_flg_d = res_flg;
      end
    end

`ifdef FPU_ISSUE_PERF_EN
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (s2_v_q && out_ready)  perf_ops_d   = perf_ops_q + 32'd1;
    if (s2_v_q && !out_ready) perf_stall_d = perf_stall_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdy_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_x1_q  <= '0;
      s1_x2_q  <= '0;
      s1_tag_q <= '0;
      s1_ca_q  <= '0;
      s1_cb_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_y_q   <= '0;
      s2_tag_q <= '0;
      s2_flg_q <= '0;
`ifdef FPU_ISSUE_PERF_EN
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
`endif
    end else begin
      rdy_q    <= rdy_d;
      s1_v_q   <= s1_v_d;
      s1_x1_q  <= s1_x1_d;
      s1_x2_q  <= s1_x2_d;
      s1_tag_q <= s1_tag_d;
      s1_ca_q  <= s1_ca_d;
      s1_cb_q  <= s1_cb_d;
      s2_v_q   <= s2_v_d;
      s2_y_q   <= s2_y_d;
      s2_tag_q <= s2_tag_d;
      s2_flg_q <= s2_flg_d;
`ifdef FPU_ISSUE_PERF_EN
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
`endif
    end
  end

  assign fu_x1     = s1_x1_q;
  assign fu_x2     = s1_x2_q;
  assign out_valid = s2_v_q;
  assign out_y     = s2_y_q;
  assign out_tag   = s2_tag_q;
  assign out_flags = s2_flg_q;
`ifdef FPU_ISSUE_PERF_EN
  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
